// File: rtl/mms_pkg.sv
// Shared types and constants for the max/min stream search block.
//   state_t : FSM encoding, ACC (accumulating a frame) / OUT (result held)
//   SEL_MAX : select value that picks the largest beat
//   SEL_MIN : select value that picks the smallest beat
package mms_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    localparam logic SEL_MAX = 1'b0;
    localparam logic SEL_MIN = 1'b1;

endpackage

// File: rtl/mms_cmp.sv
// Combinational compare/mux used to pick between a current best and a
// candidate value.
//   a      : current best (kept on ties)
//   b      : candidate
//   mode   : SEL_MAX or SEL_MIN
//   take_b : candidate strictly beats a in the chosen direction
//   y      : winning value
// The strict compare means equal values never displace a, so the earliest
// occurrence wins.
module mms_cmp
    import mms_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          mode,
    output logic          take_b,
    output logic [DW-1:0] y
);

    always_comb begin
        take_b = (mode == SEL_MIN) ? (b < a) : (b > a);
        y      = take_b ? b : a;
    end

endmodule

// File: rtl/mms_stream_search.sv
// Streaming max/min search. Consumes one unsigned beat per cycle and, on the
// frame's last beat, publishes the frame's max (select=0) or min (select=1),
// its 0-based position, the frame length (saturating) and an overflow flag.
//   clk, rst_n           : clock, asynchronous active-low reset
//   select               : direction, sampled on the first beat of a frame
//   in_valid/in_ready    : input handshake, in_data/in_last carried with it
//   out_valid/out_ready  : result handshake
//   out_data/out_idx     : winning value and its position within the frame
//   out_cnt              : beats in frame, saturates at 2**IDXW
//   out_ovf              : frame was longer than 2**IDXW beats
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid and its payload stay stable until that transfer; ready may
// be asserted regardless of valid. in_ready is high only while accumulating;
// out_valid is high only while a result is held.
module mms_stream_search
    import mms_pkg::*;
#(
    parameter int DW   = 8,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            select,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [IDXW-1:0] out_idx,
    output logic [IDXW:0]   out_cnt,
    output logic            out_ovf
);

    localparam logic [IDXW:0] CNT_MAX = {1'b1, {IDXW{1'b0}}};

    state_t          state_q, state_d;
    logic            first_q;
    logic            mode_q;
    logic [DW-1:0]   best_q;
    logic [IDXW-1:0] best_idx_q;
    logic [IDXW-1:0] pos_q;
    logic [IDXW:0]   cnt_q;
    logic            ovf_q;

    logic            beat;
    logic            cmp_mode;
    logic            cmp_take;
    logic [DW-1:0]   cmp_y;
    logic [DW-1:0]   nxt_best;
    logic [IDXW-1:0] nxt_idx;
    logic [IDXW:0]   nxt_cnt;
    logic            nxt_ovf;

    assign beat     = in_valid & in_ready;
    // On the first beat the live select governs; afterwards the latched mode.
    assign cmp_mode = first_q ? select : mode_q;

    mms_cmp #(.DW(DW)) u_cmp (
        .a      (best_q),
        .b      (in_data),
        .mode   (cmp_mode),
        .take_b (cmp_take),
        .y      (cmp_y)
    );

    // Frame-so-far values including the current beat.
    always_comb begin
        nxt_best = cmp_y;
        nxt_idx  = cmp_take ? pos_q : best_idx_q;
        nxt_cnt  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // pos wraps back to 0 only once 2**IDXW beats have already been seen.
        nxt_ovf  = ovf_q | (pos_q == '0);
        if (first_q) begin
            nxt_best = in_data;
            nxt_idx  = '0;
            nxt_cnt  = {{IDXW{1'b0}}, 1'b1};
            nxt_ovf  = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACC;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (beat && in_last) state_d = OUT;
            OUT:     if (out_ready)       state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == ACC);
        out_valid = (state_q == OUT);
    end

    // Accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q    <= 1'b1;
            mode_q     <= SEL_MAX;
            best_q     <= '0;
            best_idx_q <= '0;
            pos_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_cnt    <= '0;
            out_ovf    <= 1'b0;
        end else begin
            if (beat) begin
                first_q    <= 1'b0;
                mode_q     <= cmp_mode;
                best_q     <= nxt_best;
                best_idx_q <= nxt_idx;
                pos_q      <= first_q ? {{(IDXW-1){1'b0}}, 1'b1} : pos_q + 1'b1;
                cnt_q      <= nxt_cnt;
                ovf_q      <= nxt_ovf;
                if (in_last) begin
                    out_data <= nxt_best;
                    out_idx  <= nxt_idx;
                    out_cnt  <= nxt_cnt;
                    out_ovf  <= nxt_ovf;
                end
            end
            if (out_valid && out_ready) begin
                first_q <= 1'b1;
                ovf_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mms_stream_search.sv
module tb_mms_stream_search;

    logic       clk;
    logic       rst_n;
    logic       select;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_idx;
    logic [4:0] out_cnt;
    logic       out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    mms_stream_search #(.DW(8), .IDXW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .select    (select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat at a negedge; it transfers on the following posedge.
    task automatic send_beat(input logic [7:0] d, input logic l, input logic s);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_beat", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        select   = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h5A;
    endtask

    // Wait for a result, compare it, then accept it.
    task automatic expect_result(input string tag, input logic [7:0] d, input logic [3:0] idx,
                                 input logic [4:0] cnt, input logic ovf);
        int guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_idx"},   32'(out_idx),   32'(idx));
        check({tag, "_cnt"},   32'(out_cnt),   32'(cnt));
        check({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_clear"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        select    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_cnt",   32'(out_cnt),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // max frame 3,9,9,2 -> 9 at idx 1 (earliest tie)
        send_beat(8'd3, 1'b0, 1'b0);
        send_beat(8'd9, 1'b0, 1'b0);
        send_beat(8'd9, 1'b0, 1'b0);
        send_beat(8'd2, 1'b1, 1'b0);
        expect_result("max4", 8'd9, 4'd1, 5'd4, 1'b0);

        // min frame 7,1,5,1 -> 1 at idx 1
        send_beat(8'd7, 1'b0, 1'b1);
        send_beat(8'd1, 1'b0, 1'b1);
        send_beat(8'd5, 1'b0, 1'b1);
        send_beat(8'd1, 1'b1, 1'b1);
        expect_result("min4", 8'd1, 4'd1, 5'd4, 1'b0);

        // single beat with consumer ready: result visible the next cycle
        out_ready = 1'b1;
        send_beat(8'hAB, 1'b1, 1'b0);
        check("single_valid",    32'(out_valid), 32'd1);
        check("single_in_ready", 32'(in_ready),  32'd0);
        check("single_data",     32'(out_data),  32'hAB);
        check("single_idx",      32'(out_idx),   32'd0);
        check("single_cnt",      32'(out_cnt),   32'd1);
        @(posedge clk);
        #1;
        check("single_valid_clear", 32'(out_valid), 32'd0);
        check("single_in_ready_back", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // stall: result held stable for 5 cycles
        send_beat(8'd4, 1'b0, 1'b0);
        send_beat(8'd8, 1'b0, 1'b0);
        send_beat(8'd6, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid",    32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready),  32'd0);
            check("stall_data",     32'(out_data),  32'd8);
            check("stall_idx",      32'(out_idx),   32'd1);
            check("stall_cnt",      32'(out_cnt),   32'd3);
        end
        expect_result("stall", 8'd8, 4'd1, 5'd3, 1'b0);

        // select toggled after first beat is ignored: stays max
        send_beat(8'd5, 1'b0, 1'b0);
        send_beat(8'd2, 1'b0, 1'b1);
        send_beat(8'd9, 1'b0, 1'b1);
        send_beat(8'd1, 1'b1, 1'b1);
        expect_result("sel_toggle", 8'd9, 4'd2, 5'd4, 1'b0);

        // exactly 16 beats: full count, no overflow
        for (int i = 0; i < 16; i++)
            send_beat(8'(15 - i), (i == 15), 1'b0);
        expect_result("len16", 8'd15, 4'd0, 5'd16, 1'b0);

        // 18 beats, peak 0xFF at 0-based beat 17 -> idx 1, cnt 16, ovf
        for (int i = 0; i < 18; i++)
            send_beat((i == 17) ? 8'hFF : 8'(i), (i == 17), 1'b0);
        expect_result("len18", 8'hFF, 4'd1, 5'd16, 1'b1);

        // following frame clears overflow
        send_beat(8'd3, 1'b0, 1'b0);
        send_beat(8'd4, 1'b1, 1'b0);
        expect_result("after_ovf", 8'd4, 4'd1, 5'd2, 1'b0);

        // reset during beat 2 of a min frame discards it
        send_beat(8'd1, 1'b0, 1'b1);
        send_beat(8'd2, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd0;
        in_last  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_beat_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst_beat_in_ready", 32'(in_ready), 32'd1);
        send_beat(8'd10, 1'b0, 1'b1);
        send_beat(8'd20, 1'b0, 1'b1);
        send_beat(8'd5,  1'b1, 1'b1);
        expect_result("post_rst_beat", 8'd5, 4'd2, 5'd3, 1'b0);

        // reset while a result is held
        send_beat(8'd77, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_out_data",  32'(out_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_in_ready", 32'(in_ready), 32'd1);
        send_beat(8'h80, 1'b1, 1'b1);
        expect_result("post_rst_out", 8'h80, 4'd0, 5'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
